cam_cell_array: RTL

CAM_CELL_ARRAY -- requirements
Module: cam_cell_array

---
 rtl/cam_cell_array.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cam_cell_array.sv
// Ternary-masked CAM: WORDS x WIDTH store with per-word tag bits.
// Commands run IDLE -> EXEC -> RESP; results are registered at the EXEC edge.
module cam_cell_array #(
    parameter int WORDS = 100,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_key,
    input  logic [WIDTH-1:0] cmd_mask,
    output logic             resp_valid,
    output logic [WIDTH-1:0] read_data,
    output logic [CW-1:0]    match_count,
    output logic             any_match
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SEARCH  = 3'd1;
    localparam logic [2:0] OP_SRCH_AND = 3'd2;
    localparam logic [2:0] OP_WRITE   = 3'd3;
    localparam logic [2:0] OP_READ    = 3'd4;
    localparam logic [2:0] OP_FIRST   = 3'd5;
    localparam logic [2:0] OP_SET_ALL = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] mask_q;

    logic [WORDS-1:0] tags_q, tags_d, match;
    logic [WIDTH-1:0] store_q [WORDS];
    logic [WIDTH-1:0] store_d [WORDS];
    logic [WIDTH-1:0] rd_d;
    logic [CW-1:0]    cnt_d;
    logic             accept;

    assign cmd_ready  = rst_n && (state_q == IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign resp_valid = rst_n && (state_q == RESP);
    assign any_match  = (match_count != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        match  = '0;
        tags_d = tags_q;
        for (int i = 0; i < WORDS; i++) begin
            match[i]   = (((store_q[i] ^ key_q) & mask_q) == '0);
            store_d[i] = store_q[i];
        end
        unique case (op_q)
            OP_SEARCH:   tags_d = match;
            OP_SRCH_AND: tags_d = tags_q & match;
            OP_FIRST:    tags_d = tags_q & (~tags_q + WORDS'(1));
            OP_SET_ALL:  tags_d = '1;
            OP_CLEAR:    tags_d = '0;
            OP_WRITE: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (tags_q[i])
                        store_d[i] = (store_q[i] & ~mask_q) | (key_q & mask_q);
                end
            end
            OP_NOP, OP_READ: tags_d = tags_q;
            default:         tags_d = tags_q;
        endcase
        // Results are taken from the post-update state.
        rd_d  = '0;
        cnt_d = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (tags_d[i]) rd_d = rd_d | store_d[i];
            cnt_d = cnt_d + CW'(tags_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tags_q      <= '0;
            read_data   <= '0;
            match_count <= '0;
            for (int i = 0; i < WORDS; i++) store_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == EXEC) begin
                tags_q      <= tags_d;
                read_data   <= rd_d;
                match_count <= cnt_d;
                for (int i = 0; i < WORDS; i++) store_q[i] <= store_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= cmd_op;
            key_q  <= cmd_key;
            mask_q <= cmd_mask;
        end
    end

endmodule
